// File: rtl/sa_seq_ctrl.sv
// Sequencer for the output-stationary systolic array: walks WARMUP/STEADY/DRAIN per tile and emits SRAM read windows.
// Latency: start accepted at edge N shows WARMUP and tile-0 windows after N; every output is a register.
// Backpressure: none; start is honoured only in IDLE outside the done cycle, abort forces IDLE from any busy state.
module sa_seq_ctrl #(
  parameter int NUM_ROW              = 4,
  parameter int NUM_COL              = 4,
  parameter int LOG2_SRAM_BANK_DEPTH = 5,
  parameter int CTRL_WIDTH           = 4,
  parameter int TILE_CNT_WIDTH       = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_start,
  input  logic                              i_abort,
  input  logic [TILE_CNT_WIDTH-1:0]         i_num_tiles,
  input  logic [LOG2_SRAM_BANK_DEPTH:0]     i_k_len,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0]   i_top_base_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0]   i_left_base_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0]   i_down_base_addr,
  output logic [CTRL_WIDTH-1:0]             o_ctrl_state,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]   o_top_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]   o_top_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]   o_left_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]   o_left_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]   o_down_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]   o_down_sram_rd_end_addr,
  output logic [TILE_CNT_WIDTH-1:0]         o_tile_idx,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_aborted
);

  localparam int AW = LOG2_SRAM_BANK_DEPTH;
  localparam int KW = LOG2_SRAM_BANK_DEPTH + 1;
  // K_eff can reach 2^KW-1 (wider than the bank), so size the counter for the longest STEADY phase.
  localparam int CNT_W = $clog2((1 << KW) + NUM_ROW + NUM_COL);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_STEADY = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // Configuration captured in the start cycle; held for the whole run.
  typedef struct packed {
    logic [TILE_CNT_WIDTH-1:0] num_tiles;
    logic [KW-1:0]             k_eff;
  } cfg_t;

  state_t           state;
  cfg_t             cfg_q;
  logic [CNT_W-1:0] cnt;

  logic [KW-1:0]    k_eff_in;
  logic [AW-1:0]    k_step_in;
  logic [AW-1:0]    k_step_q;
  logic [AW-1:0]    row_step;
  logic [CNT_W-1:0] warm_load_in;
  logic [CNT_W-1:0] warm_load_q;
  logic [CNT_W-1:0] steady_load;
  logic [CNT_W-1:0] drain_load;
  logic             start_ok;
  logic             last_tile;
  logic             phase_end;

  // K=0 is treated as K=1 so every phase lasts at least one cycle.
  assign k_eff_in  = (i_k_len == '0) ? KW'(1) : i_k_len;
  // Window steps are taken modulo the bank depth, so only the low AW bits matter.
  assign k_step_in = k_eff_in[AW-1:0];
  assign k_step_q  = cfg_q.k_eff[AW-1:0];
  assign row_step  = AW'(NUM_ROW);

  // Down-counters are loaded with (phase length - 1) and the phase ends when they reach zero.
  assign warm_load_in = CNT_W'(k_eff_in) - CNT_W'(1);
  assign warm_load_q  = CNT_W'(cfg_q.k_eff) - CNT_W'(1);
  assign steady_load  = CNT_W'(cfg_q.k_eff) + CNT_W'(NUM_ROW + NUM_COL - 2) - CNT_W'(1);
  assign drain_load   = CNT_W'(NUM_ROW - 1);

  // The cycle carrying the done pulse is a dead cycle for start.
  assign start_ok  = i_start && !o_done;
  assign last_tile = (o_tile_idx == (cfg_q.num_tiles - TILE_CNT_WIDTH'(1)));
  assign phase_end = (cnt == '0);

  assign o_ctrl_state = CTRL_WIDTH'(state);

  // Sequencer FSM: config capture, phase timing, tile stepping and window generation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                     <= ST_IDLE;
      cfg_q                     <= '0;
      cnt                       <= '0;
      o_top_sram_rd_start_addr  <= '0;
      o_top_sram_rd_end_addr    <= '0;
      o_left_sram_rd_start_addr <= '0;
      o_left_sram_rd_end_addr   <= '0;
      o_down_sram_rd_start_addr <= '0;
      o_down_sram_rd_end_addr   <= '0;
      o_tile_idx                <= '0;
      o_busy                    <= 1'b0;
      o_done                    <= 1'b0;
      o_aborted                 <= 1'b0;
    end else begin
      o_done    <= 1'b0;
      o_aborted <= 1'b0;

      if (state == ST_IDLE) begin
        // Abort has no meaning in IDLE, so a start is taken even when abort is also high.
        if (start_ok) begin
          cfg_q <= '{num_tiles: i_num_tiles, k_eff: k_eff_in};
          if (i_num_tiles == '0) begin
            o_done <= 1'b1;
          end else begin
            state                     <= ST_WARMUP;
            o_busy                    <= 1'b1;
            o_tile_idx                <= '0;
            cnt                       <= warm_load_in;
            o_top_sram_rd_start_addr  <= i_top_base_addr;
            o_top_sram_rd_end_addr    <= i_top_base_addr + k_step_in;
            o_left_sram_rd_start_addr <= i_left_base_addr;
            o_left_sram_rd_end_addr   <= i_left_base_addr + k_step_in;
            o_down_sram_rd_start_addr <= i_down_base_addr;
            o_down_sram_rd_end_addr   <= i_down_base_addr + row_step;
          end
        end
      end else if (i_abort) begin
        // Abort drops straight to IDLE; windows keep their last values, tile index restarts at 0.
        state      <= ST_IDLE;
        o_busy     <= 1'b0;
        o_aborted  <= 1'b1;
        o_tile_idx <= '0;
        cnt        <= '0;
      end else if (!phase_end) begin
        cnt <= cnt - CNT_W'(1);
      end else begin
        case (state)
          ST_WARMUP: begin
            state <= ST_STEADY;
            cnt   <= steady_load;
          end
          ST_STEADY: begin
            state <= ST_DRAIN;
            cnt   <= drain_load;
          end
          ST_DRAIN: begin
            if (last_tile) begin
              state      <= ST_IDLE;
              o_busy     <= 1'b0;
              o_done     <= 1'b1;
              o_tile_idx <= '0;
              cnt        <= '0;
            end else begin
              // Next tile begins immediately; each window starts where the previous one ended.
              state                     <= ST_WARMUP;
              o_tile_idx                <= o_tile_idx + TILE_CNT_WIDTH'(1);
              cnt                       <= warm_load_q;
              o_top_sram_rd_start_addr  <= o_top_sram_rd_end_addr;
              o_top_sram_rd_end_addr    <= o_top_sram_rd_end_addr + k_step_q;
              o_left_sram_rd_start_addr <= o_left_sram_rd_end_addr;
              o_left_sram_rd_end_addr   <= o_left_sram_rd_end_addr + k_step_q;
              o_down_sram_rd_start_addr <= o_down_sram_rd_end_addr;
              o_down_sram_rd_end_addr   <= o_down_sram_rd_end_addr + row_step;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Directed bench for sa_seq_ctrl with hand-computed windows and phase lengths.
// Latency: outputs are sampled on falling edges, one edge after the inputs are driven.
// Backpressure: not applicable; every wait on the DUT is bounded by a cycle budget.
module tb_sa_seq_ctrl;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic          i_abort;
  logic [TW-1:0] i_num_tiles;
  logic [AW:0]   i_k_len;
  logic [AW-1:0] i_top_base_addr;
  logic [AW-1:0] i_left_base_addr;
  logic [AW-1:0] i_down_base_addr;
  logic [CW-1:0] o_ctrl_state;
  logic [AW-1:0] o_top_sram_rd_start_addr;
  logic [AW-1:0] o_top_sram_rd_end_addr;
  logic [AW-1:0] o_left_sram_rd_start_addr;
  logic [AW-1:0] o_left_sram_rd_end_addr;
  logic [AW-1:0] o_down_sram_rd_start_addr;
  logic [AW-1:0] o_down_sram_rd_end_addr;
  logic [TW-1:0] o_tile_idx;
  logic          o_busy;
  logic          o_done;
  logic          o_aborted;

  int n_vec = 0;
  int n_bad = 0;

  // Expected windows for the 3-tile K=8 run (top base 24, left base 5, down base 0, mod 32).
  int mt_ts[3] = '{24, 0, 8};
  int mt_te[3] = '{0, 8, 16};
  int mt_ls[3] = '{5, 13, 21};
  int mt_le[3] = '{13, 21, 29};
  int mt_ds[3] = '{0, 4, 8};
  int mt_de[3] = '{4, 8, 12};

  always #5 clk = ~clk;

  sa_seq_ctrl #(
    .NUM_ROW(NR), .NUM_COL(NC), .LOG2_SRAM_BANK_DEPTH(AW),
    .CTRL_WIDTH(CW), .TILE_CNT_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_num_tiles(i_num_tiles), .i_k_len(i_k_len),
    .i_top_base_addr(i_top_base_addr), .i_left_base_addr(i_left_base_addr),
    .i_down_base_addr(i_down_base_addr),
    .o_ctrl_state(o_ctrl_state),
    .o_top_sram_rd_start_addr(o_top_sram_rd_start_addr),
    .o_top_sram_rd_end_addr(o_top_sram_rd_end_addr),
    .o_left_sram_rd_start_addr(o_left_sram_rd_start_addr),
    .o_left_sram_rd_end_addr(o_left_sram_rd_end_addr),
    .o_down_sram_rd_start_addr(o_down_sram_rd_start_addr),
    .o_down_sram_rd_end_addr(o_down_sram_rd_end_addr),
    .o_tile_idx(o_tile_idx), .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_win(input string tag, input int ts, input int te, input int ls,
                         input int le, input int ds, input int de);
    chk({tag, "_top_start"},  32'(o_top_sram_rd_start_addr),  ts);
    chk({tag, "_top_end"},    32'(o_top_sram_rd_end_addr),    te);
    chk({tag, "_left_start"}, 32'(o_left_sram_rd_start_addr), ls);
    chk({tag, "_left_end"},   32'(o_left_sram_rd_end_addr),   le);
    chk({tag, "_down_start"}, 32'(o_down_sram_rd_start_addr), ds);
    chk({tag, "_down_end"},   32'(o_down_sram_rd_end_addr),   de);
  endtask

  // Count falling edges spent in state st; bounded so a stuck FSM still reaches the summary.
  task automatic measure(input logic [CW-1:0] st, output int n);
    n = 0;
    while (o_ctrl_state == st && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic start_cfg(input int nt, input int k, input int tb, input int lb, input int db);
    i_num_tiles      = TW'(nt);
    i_k_len          = (AW+1)'(k);
    i_top_base_addr  = AW'(tb);
    i_left_base_addr = AW'(lb);
    i_down_base_addr = AW'(db);
    i_start          = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  initial begin
    int w, s, d, total, seen;
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_num_tiles = '0; i_k_len = '0;
    i_top_base_addr = '0; i_left_base_addr = '0; i_down_base_addr = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_state", 32'(o_ctrl_state), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_aborted", 32'(o_aborted), 0);
    chk("rst_tile", 32'(o_tile_idx), 0);
    chk_win("rst", 0, 0, 0, 0, 0, 0);

    // Single tile, start on the first edge after reset release.
    rst = 1'b0;
    start_cfg(1, 4, 0, 0, 0);
    chk("st_state", 32'(o_ctrl_state), 1);
    chk("st_busy", 32'(o_busy), 1);
    chk("st_tile", 32'(o_tile_idx), 0);
    chk_win("st", 0, 4, 0, 4, 0, 4);
    measure(1, w); chk("st_warmup_len", w, 4);
    measure(2, s); chk("st_steady_len", s, 10);
    measure(3, d); chk("st_drain_len", d, 4);
    chk("st_total", w + s + d, 18);
    chk("st_end_state", 32'(o_ctrl_state), 0);
    chk("st_done", 32'(o_done), 1);
    chk("st_end_busy", 32'(o_busy), 0);
    chk_win("st_hold", 0, 4, 0, 4, 0, 4);

    // Start during the done cycle is ignored; held one more cycle it is taken.
    i_num_tiles = 1; i_k_len = 1; i_top_base_addr = 9; i_start = 1'b1;
    @(negedge clk);
    chk("dc_done_cleared", 32'(o_done), 0);
    chk("dc_start_ignored", 32'(o_ctrl_state), 0);
    @(negedge clk);
    i_start = 1'b0;
    chk("dc_start_taken", 32'(o_ctrl_state), 1);
    chk("dc_top_start", 32'(o_top_sram_rd_start_addr), 9);
    chk("dc_top_end", 32'(o_top_sram_rd_end_addr), 10);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("dc_abort_state", 32'(o_ctrl_state), 0);
    chk("dc_aborted", 32'(o_aborted), 1);
    @(negedge clk);
    chk("dc_aborted_clr", 32'(o_aborted), 0);

    // Three tiles, K=8, top window wraps through address 0.
    start_cfg(3, 8, 24, 5, 0);
    total = 0;
    for (int t = 0; t < 3; t++) begin
      chk("mt_state", 32'(o_ctrl_state), 1);
      chk("mt_busy", 32'(o_busy), 1);
      chk("mt_tile", 32'(o_tile_idx), t);
      chk_win("mt", mt_ts[t], mt_te[t], mt_ls[t], mt_le[t], mt_ds[t], mt_de[t]);
      measure(1, w); chk("mt_warmup_len", w, 8);
      measure(2, s); chk("mt_steady_len", s, 14);
      measure(3, d); chk("mt_drain_len", d, 4);
      total += w + s + d;
    end
    chk("mt_total", total, 3 * (8 + 14 + 4));
    chk("mt_done", 32'(o_done), 1);
    chk("mt_end_tile", 32'(o_tile_idx), 0);
    chk_win("mt_hold", 8, 16, 21, 29, 8, 12);
    @(negedge clk);

    // Zero tiles: done pulse without ever going busy.
    start_cfg(0, 4, 0, 0, 0);
    chk("z_done", 32'(o_done), 1);
    chk("z_busy", 32'(o_busy), 0);
    chk("z_state", 32'(o_ctrl_state), 0);
    @(negedge clk);
    chk("z_done_clr", 32'(o_done), 0);
    chk("z_busy2", 32'(o_busy), 0);

    // K=0 runs as K=1; down window wraps 30 -> 2.
    start_cfg(1, 0, 3, 3, 30);
    chk_win("k0", 3, 4, 3, 4, 30, 2);
    measure(1, w); chk("k0_warmup_len", w, 1);
    measure(2, s); chk("k0_steady_len", s, 7);
    measure(3, d); chk("k0_drain_len", d, 4);
    chk("k0_done", 32'(o_done), 1);
    @(negedge clk);

    // Abort together with start in IDLE: start wins.
    i_abort = 1'b1;
    start_cfg(2, 4, 1, 2, 3);
    i_abort = 1'b0;
    chk("ab_state", 32'(o_ctrl_state), 1);
    // Start while busy must not disturb windows or tile index.
    i_num_tiles = 5; i_k_len = 9; i_top_base_addr = 17; i_left_base_addr = 17;
    i_down_base_addr = 17; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("ab_busy_tile", 32'(o_tile_idx), 0);
    chk_win("ab_busy", 1, 5, 2, 6, 3, 7);
    measure(1, w); chk("ab_warmup_rest", w, 3);
    @(negedge clk); @(negedge clk);
    chk("ab_steady3", 32'(o_ctrl_state), 2);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("ab_idle", 32'(o_ctrl_state), 0);
    chk("ab_aborted", 32'(o_aborted), 1);
    chk("ab_no_done", 32'(o_done), 0);
    chk("ab_busy", 32'(o_busy), 0);
    chk("ab_tile", 32'(o_tile_idx), 0);
    @(negedge clk);
    chk("ab_aborted_clr", 32'(o_aborted), 0);
    chk("ab_no_done2", 32'(o_done), 0);

    // Asynchronous reset in the middle of STEADY.
    start_cfg(1, 4, 7, 7, 7);
    measure(1, w);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_state", 32'(o_ctrl_state), 0);
    chk("mr_busy", 32'(o_busy), 0);
    chk_win("mr", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (o_done || o_aborted || o_busy) seen++;
    end
    chk("mr_quiet_after", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
